rib_bus: RTL and testbench

RIB_BUS -- requirements
Module: rib_bus

---
 rtl/rib_bus_if.sv | 34 +++
 rtl/rib_bus.sv | 153 +++++++++++++++
 tb/tb_rib_bus.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rib_bus_if.sv
// Bundled master- and slave-side signals of the RIB crossbar.
// Addresses and data are 32 bits wide.
interface rib_bus_if #(
  parameter int NM = 4,
  parameter int NS = 8
);
  logic [NM-1:0][31:0] m_addr_i;
  logic [NM-1:0][31:0] m_data_i;
  logic [NM-1:0]       m_req_i;
  logic [NM-1:0]       m_we_i;
  logic [NM-1:0][31:0] m_data_o;
  logic [NM-1:0]       m_ready_o;
  logic [NM-1:0]       m_err_o;
  logic [NS-1:0][31:0] s_addr_o;
  logic [NS-1:0][31:0] s_data_o;
  logic [NS-1:0]       s_we_o;
  logic [NS-1:0]       s_req_o;
  logic [NS-1:0][31:0] s_data_i;
  logic [NS-1:0]       s_ready_i;
  logic                hold_flag_o;

  // slave: the fabric itself; master: the surrounding cores and memories
  modport slave (
    input  m_addr_i, m_data_i, m_req_i, m_we_i, s_data_i, s_ready_i,
    output m_data_o, m_ready_o, m_err_o, s_addr_o, s_data_o, s_we_o, s_req_o,
           hold_flag_o
  );

  modport master (
    output m_addr_i, m_data_i, m_req_i, m_we_i, s_data_i, s_ready_i,
    input  m_data_o, m_ready_o, m_err_o, s_addr_o, s_data_o, s_we_o, s_req_o,
           hold_flag_o
  );
endinterface

// File: rtl/rib_bus.sv
// RIB crossbar: arbitrates NM masters onto NS slaves (addr[31:28] selects),
// with zero-wait completion, frozen grant while waiting, timeout and abort.
module rib_bus #(
  parameter int         NM         = 4,
  parameter int         NS         = 8,
  parameter int         ARB_RR     = 0,
  parameter logic [7:0] HOLD_MASK  = 8'b0000_1100,
  parameter int         NOP_MASTER = 1,
  parameter int         TIMEOUT    = 16
) (
  input logic      clk,
  input logic      rst,
  rib_bus_if.slave bus
);
  localparam int          MW          = $clog2(NM);
  localparam int          CW          = $clog2(TIMEOUT + 1);
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic        HoldEnable  = 1'b1;
  localparam logic        HoldDisable = 1'b0;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   gnt_q, gnt_d;
  logic [MW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [MW-1:0]   arb_idx, cand, cur;
  logic            arb_found, active, timed_out, in_range, drive;
  logic            done, err, sel_ready;
  logic [3:0]      sel;
  logic [31:0]     sel_rdata;
  int unsigned     sum;

  logic [NM-1:0][31:0] m_data;
  logic [NM-1:0]       m_ready, m_err;
  logic [NS-1:0][31:0] s_addr, s_data;
  logic [NS-1:0]       s_we, s_req;
  logic                hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int unsigned i = 0; i < NM; i++) begin
      sum = (ARB_RR != 0) ? 32'(rr_ptr_q) + i : i;
      if (sum >= NM) sum = sum - NM;
      cand = MW'(sum);
      if (!arb_found && bus.m_req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    m_data    = '0;
    m_ready   = '0;
    m_err     = '0;
    s_addr    = '0;
    s_data    = '0;
    s_we      = '0;
    s_req     = '0;
    sel_ready = 1'b0;
    sel_rdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    m_data[MW'(NOP_MASTER)] = INST_NOP;

    // in WAIT the registered grant is frozen; a dropped request aborts it
    cur       = (state_q == WAIT) ? gnt_q : arb_idx;
    active    = (state_q == WAIT) ? bus.m_req_i[gnt_q] : arb_found;
    timed_out = (state_q == WAIT) && (tmo_cnt_q == CW'(TIMEOUT - 1));
    sel       = bus.m_addr_i[cur][31:28];
    in_range  = 32'(sel) < 32'(NS);
    drive     = active && in_range && !timed_out && !rst;

    for (int unsigned j = 0; j < NS; j++) begin
      if (sel == 4'(j)) begin
        sel_ready = bus.s_ready_i[j];
        sel_rdata = bus.s_data_i[j];
        if (drive) begin
          s_req[j]  = 1'b1;
          s_we[j]   = bus.m_we_i[cur];
          s_addr[j] = bus.m_addr_i[cur];
          s_data[j] = bus.m_data_i[cur];
        end
      end
    end

    if (active) begin
      if (!in_range || timed_out) begin
        done = 1'b1;
        err  = 1'b1;
      end else if (sel_ready) begin
        done = 1'b1;
      end
    end

    if (!active) begin
      state_d   = IDLE;
      tmo_cnt_d = '0;
    end else if (done) begin
      state_d   = IDLE;
      tmo_cnt_d = '0;
      if (ARB_RR != 0)
        rr_ptr_d = (cur == MW'(NM - 1)) ? '0 : cur + 1'b1;
    end else if (state_q == IDLE) begin
      state_d   = WAIT;
      gnt_d     = cur;
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    if (active && !rst) begin
      m_ready[cur] = done;
      m_err[cur]   = err;
      m_data[cur]  = (done && !err) ? sel_rdata : '0;
    end

    hold = (!rst && ((|(bus.m_req_i & HOLD_MASK[NM-1:0])) || state_q == WAIT))
           ? HoldEnable : HoldDisable;
  end

  assign bus.m_data_o    = m_data;
  assign bus.m_ready_o   = m_ready;
  assign bus.m_err_o     = m_err;
  assign bus.s_addr_o    = s_addr;
  assign bus.s_data_o    = s_data;
  assign bus.s_we_o      = s_we;
  assign bus.s_req_o     = s_req;
  assign bus.hold_flag_o = hold;
endmodule

// File: tb/tb_rib_bus.sv
// Drives two crossbar configurations (fixed/NS=8/TIMEOUT=16 and RR/NS=4/TIMEOUT=4)
// with shared master stimulus and checks them against a transaction-level model.
module tb_rib_bus;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0][31:0] m_addr, m_wdata;
  logic [3:0]       m_req, m_we;
  logic [7:0][31:0] s_rdata;
  logic [7:0]       s_rdy;

  rib_bus_if #(.NM(4), .NS(8)) bus_a ();
  rib_bus_if #(.NM(4), .NS(4)) bus_b ();

  assign bus_a.m_addr_i  = m_addr;
  assign bus_a.m_data_i  = m_wdata;
  assign bus_a.m_req_i   = m_req;
  assign bus_a.m_we_i    = m_we;
  assign bus_a.s_data_i  = s_rdata;
  assign bus_a.s_ready_i = s_rdy;
  assign bus_b.m_addr_i  = m_addr;
  assign bus_b.m_data_i  = m_wdata;
  assign bus_b.m_req_i   = m_req;
  assign bus_b.m_we_i    = m_we;
  assign bus_b.s_data_i  = s_rdata[3:0];
  assign bus_b.s_ready_i = s_rdy[3:0];

  rib_bus #(.NM(4), .NS(8), .ARB_RR(0), .HOLD_MASK(8'b0000_1100),
            .NOP_MASTER(1), .TIMEOUT(16))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  rib_bus #(.NM(4), .NS(4), .ARB_RR(1), .HOLD_MASK(8'b0000_1100),
            .NOP_MASTER(1), .TIMEOUT(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic expect_eq(input string tag, input logic [511:0] got,
                           input logic [511:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passed++;
  endtask

  // Transaction model: one outstanding transfer per bus, tracked as owner + elapsed wait cycles
  bit          busy[2]   = '{0, 0};
  int unsigned owner[2]  = '{0, 0};
  int unsigned waited[2] = '{0, 0};
  int unsigned ptr[2]    = '{0, 0};
  bit          nb[2];
  int unsigned no[2], nw[2], np[2];

  logic [3:0]       e_rdy, e_err;
  logic [3:0][31:0] e_mdata;
  logic [7:0]       e_sreq, e_swe;
  logic [7:0][31:0] e_saddr, e_sdata;
  logic             e_hold;

  task automatic model_eval(input int d);
    int unsigned ns, tmo, who, slv, c;
    bit rr, live, expire, finish;
    ns = (d != 0) ? 4 : 8;
    tmo = (d != 0) ? 4 : 16;
    rr = (d != 0);
    e_rdy = '0; e_err = '0; e_mdata = '0; e_mdata[1] = NOP;
    e_sreq = '0; e_swe = '0; e_saddr = '0; e_sdata = '0; e_hold = 1'b0;
    nb[d] = busy[d]; no[d] = owner[d]; nw[d] = waited[d]; np[d] = ptr[d];
    finish = 0;
    if (rst) begin
      nb[d] = 0; no[d] = 0; nw[d] = 0; np[d] = 0;
    end else begin
      e_hold = ((m_req & 4'b1100) != 4'b0000) || busy[d];
      live = 0; who = 0;
      if (busy[d]) begin
        who = owner[d];
        live = m_req[who];
      end else begin
        for (int k = 0; k < 4; k++) begin
          c = rr ? (ptr[d] + k) % 4 : k;
          if (!live && m_req[c]) begin who = c; live = 1; end
        end
      end
      if (!live) begin
        nb[d] = 0; nw[d] = 0;
      end else begin
        e_mdata[who] = '0;
        slv = 32'(m_addr[who][31:28]);
        expire = busy[d] && (waited[d] + 1 == tmo);
        if (slv >= ns || expire) begin
          e_rdy[who] = 1'b1; e_err[who] = 1'b1; finish = 1;
        end else begin
          e_sreq[slv] = 1'b1; e_swe[slv] = m_we[who];
          e_saddr[slv] = m_addr[who]; e_sdata[slv] = m_wdata[who];
          if (s_rdy[slv]) begin
            e_rdy[who] = 1'b1; e_mdata[who] = s_rdata[slv]; finish = 1;
          end else if (busy[d]) begin
            nw[d] = waited[d] + 1;
          end else begin
            nb[d] = 1; no[d] = who; nw[d] = 0;
          end
        end
        if (finish) begin
          nb[d] = 0; nw[d] = 0;
          if (rr) np[d] = (who + 1) % 4;
        end
      end
    end
  endtask

  task automatic compare(input int d);
    if (d == 0) begin
      expect_eq("a.ready", bus_a.m_ready_o, e_rdy);
      expect_eq("a.err",   bus_a.m_err_o,   e_err);
      expect_eq("a.mdata", bus_a.m_data_o,  e_mdata);
      expect_eq("a.sreq",  bus_a.s_req_o,   e_sreq);
      expect_eq("a.swe",   bus_a.s_we_o,    e_swe);
      expect_eq("a.saddr", bus_a.s_addr_o,  e_saddr);
      expect_eq("a.sdata", bus_a.s_data_o,  e_sdata);
      expect_eq("a.hold",  bus_a.hold_flag_o, e_hold);
    end else begin
      expect_eq("b.ready", bus_b.m_ready_o, e_rdy);
      expect_eq("b.err",   bus_b.m_err_o,   e_err);
      expect_eq("b.mdata", bus_b.m_data_o,  e_mdata);
      expect_eq("b.sreq",  bus_b.s_req_o,   e_sreq);
      expect_eq("b.swe",   bus_b.s_we_o,    e_swe);
      expect_eq("b.saddr", bus_b.s_addr_o,  e_saddr);
      expect_eq("b.sdata", bus_b.s_data_o,  e_sdata);
      expect_eq("b.hold",  bus_b.hold_flag_o, e_hold);
    end
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      model_eval(d);
      compare(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      busy[d] = nb[d]; owner[d] = no[d]; waited[d] = nw[d]; ptr[d] = np[d];
    end
    @(negedge clk);
  endtask

  bit          found;
  int unsigned at;

  initial begin
    rst = 1'b1; m_req = 4'b1111; m_we = '0; m_addr = '0; m_wdata = '0;
    s_rdy = '0; s_rdata = '0;
    @(negedge clk);
    #1;
    expect_eq("rst.hold",  bus_a.hold_flag_o, 1'b0);
    expect_eq("rst.ready", bus_a.m_ready_o, 4'b0000);
    cycle(); cycle();
    rst = 1'b0; m_req = '0;
    cycle();

    // zero-wait read from slave 1
    m_req = 4'b0001; m_addr[0] = 32'h1000_0004; s_rdy = 8'b0000_0010;
    s_rdata[1] = 32'hDEAD_BEEF;
    #1;
    expect_eq("zw.ready", bus_a.m_ready_o[0], 1'b1);
    expect_eq("zw.data",  bus_a.m_data_o[0], 32'hDEAD_BEEF);
    expect_eq("zw.nop",   bus_a.m_data_o[1], NOP);
    cycle();
    m_req = '0; cycle();

    // write with three not-ready cycles; m0 ignored while waiting, served afterwards
    m_req = 4'b0100; m_addr[2] = 32'h6000_0000; m_we[2] = 1'b1; m_wdata[2] = 32'hA5A5_0006;
    #1;
    expect_eq("ws.we1",   bus_a.s_we_o, 8'h40);
    expect_eq("ws.hold",  bus_a.hold_flag_o, 1'b1);
    cycle();
    m_req = 4'b0101; m_addr[0] = 32'h1000_0000;
    for (int i = 0; i < 2; i++) begin
      #1;
      expect_eq("ws.wewait", bus_a.s_we_o, 8'h40);
      expect_eq("ws.m0idle", bus_a.m_ready_o, 4'b0000);
      cycle();
    end
    s_rdy[6] = 1'b1;
    #1;
    expect_eq("ws.done", bus_a.m_ready_o, 4'b0100);
    cycle();
    m_req = 4'b0001; m_we[2] = 1'b0;
    #1;
    expect_eq("ws.next", bus_a.m_ready_o, 4'b0001);
    cycle();
    m_req = '0; cycle();

    // round-robin rotation from a freshly reset pointer
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 4; i++) m_addr[i] = {4'(i), 28'h0};
    m_req = 4'b1111; s_rdy = '1;
    for (int i = 0; i < 5; i++) begin
      #1;
      expect_eq("rr.grant",  bus_b.m_ready_o, 4'b0001 << (i % 4));
      expect_eq("fix.grant", bus_a.m_ready_o, 4'b0001);
      cycle();
    end
    m_req = '0; cycle();

    // slave 7 never ready: forced error on the 16th wait cycle
    m_req = 4'b0010; m_addr[1] = 32'h7000_0000; s_rdy = '0;
    found = 0; at = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (bus_a.m_ready_o[1]) begin
        found = 1; at = c;
        expect_eq("tmo.err",  bus_a.m_err_o[1], 1'b1);
        expect_eq("tmo.data", bus_a.m_data_o[1], 32'h0);
        expect_eq("tmo.sreq", bus_a.s_req_o, 8'h00);
      end
      cycle();
    end
    expect_eq("tmo.found", found, 1'b1);
    expect_eq("tmo.cycle", at, 16);
    m_req = '0;
    #1;
    expect_eq("tmo.idle", bus_a.hold_flag_o, 1'b0);
    cycle();

    // unmapped slave on the 4-slave bus
    m_req = 4'b0001; m_addr[0] = 32'h5000_0000;
    #1;
    expect_eq("unm.err",  bus_b.m_err_o[0], 1'b1);
    expect_eq("unm.rdy",  bus_b.m_ready_o[0], 1'b1);
    expect_eq("unm.sreq", bus_b.s_req_o, 4'h0);
    cycle();
    m_req = '0; cycle();

    // reset while waiting drops the transfer
    m_req = 4'b1000; m_addr[3] = 32'h2000_0000; s_rdy = '0;
    cycle(); cycle();
    rst = 1'b1; s_rdy = '1;
    #1;
    expect_eq("rw.ready", bus_a.m_ready_o, 4'b0000);
    expect_eq("rw.sreq",  bus_a.s_req_o, 8'h00);
    expect_eq("rw.hold",  bus_a.hold_flag_o, 1'b0);
    cycle();
    rst = 1'b0; m_req = '0;
    #1;
    expect_eq("rw.idle",  bus_a.hold_flag_o, 1'b0);
    expect_eq("rw.none",  bus_a.m_ready_o, 4'b0000);
    cycle();

    // randomized traffic: sticky requests, flaky slaves, occasional reset
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) begin
          m_req[i] = ~m_req[i];
          if (m_req[i]) begin
            m_addr[i]  = {4'($urandom_range(9)), 28'($urandom)};
            m_we[i]    = 1'($urandom);
            m_wdata[i] = $urandom;
          end
        end
      end
      for (int j = 0; j < 8; j++) begin
        s_rdy[j]   = ($urandom_range(4) > 1);
        s_rdata[j] = $urandom;
      end
      if (n < 1000) s_rdy[7] = 1'b0;
      rst = ($urandom_range(199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
